// File: rtl/bus_master_bridge.sv
// Register-bus master: valid/ready command in, single-cycle re/we strobe out, ack or timeout response back.
// Optional sticky bus interrupt output enabled by defining BUS_MASTER_IRQ_EN.

package bus_master_bridge_pkg;
  localparam int unsigned BUS_ADDR_WIDTH = 16;
  localparam int unsigned BUS_DATA_WIDTH = 32;

  // bus_in layout, MSB first: clk, reset_l, addr, wr_data, re, we
  localparam int unsigned BUS_IN_WE        = 0;
  localparam int unsigned BUS_IN_RE        = 1;
  localparam int unsigned BUS_IN_WDATA_LSB = 2;
  localparam int unsigned BUS_IN_ADDR_LSB  = BUS_IN_WDATA_LSB + BUS_DATA_WIDTH;
  localparam int unsigned BUS_IN_RESET_L   = BUS_IN_ADDR_LSB + BUS_ADDR_WIDTH;
  localparam int unsigned BUS_IN_CLK       = BUS_IN_RESET_L + 1;
  localparam int unsigned BUS_IN_WIDTH     = BUS_IN_CLK + 1;

  // bus_out layout, MSB first: rd_data, rd_ack, wr_ack, irq
  localparam int unsigned BUS_OUT_IRQ         = 0;
  localparam int unsigned BUS_OUT_WR_ACK      = 1;
  localparam int unsigned BUS_OUT_RD_ACK      = 2;
  localparam int unsigned BUS_OUT_RDATA_LSB   = 3;
  localparam int unsigned BUS_OUT_WIDTH       = BUS_OUT_RDATA_LSB + BUS_DATA_WIDTH;
endpackage

module bus_master_bridge
  import bus_master_bridge_pkg::*;
#(
  parameter int unsigned                  TIMEOUT  = 16,
  parameter logic [BUS_DATA_WIDTH-1:0]    ERR_DATA = '0
) (
  input  logic                      bus_clk,
  input  logic                      bus_reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [BUS_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [BUS_DATA_WIDTH-1:0] cmd_wr_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [BUS_DATA_WIDTH-1:0] rsp_rd_data,
  output logic                      rsp_err,
  output logic [BUS_IN_WIDTH-1:0]   bus_in,
  input  logic [BUS_OUT_WIDTH-1:0]  bus_out
`ifdef BUS_MASTER_IRQ_EN
  ,
  output logic                      irq,
  input  logic                      irq_clr
`endif
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      op_we_q, op_we_d;
  logic                      re_q, re_d, we_q, we_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [BUS_DATA_WIDTH-1:0] rsp_rd_data_q, rsp_rd_data_d;
  logic                      rsp_err_q, rsp_err_d;

  logic                      rd_ack, wr_ack, ack_match;
  logic [BUS_DATA_WIDTH-1:0] bus_rd_data;

  assign rd_ack      = bus_out[BUS_OUT_RD_ACK];
  assign wr_ack      = bus_out[BUS_OUT_WR_ACK];
  assign bus_rd_data = bus_out[BUS_OUT_RDATA_LSB +: BUS_DATA_WIDTH];
  assign ack_match   = op_we_q ? wr_ack : rd_ack;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    op_we_d       = op_we_q;
    re_d          = 1'b0;
    we_d          = 1'b0;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rd_data_d = rsp_rd_data_q;
    rsp_err_d     = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wr_data;
          op_we_d     = cmd_we;
          re_d        = ~cmd_we;
          we_d        = cmd_we;
          cmd_ready_d = 1'b0;
          state_d     = STROBE;
        end
      end
      STROBE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A matching ack on the expiry cycle takes priority over the timeout
        if (ack_match) begin
          rsp_rd_data_d = op_we_q ? '0 : bus_rd_data;
          rsp_err_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
          rsp_rd_data_d = op_we_q ? '0 : ERR_DATA;
          rsp_err_d     = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (cnt_q != CNT_W'(TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      op_we_q       <= 1'b0;
      re_q          <= 1'b0;
      we_q          <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rd_data_q <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      op_we_q       <= op_we_d;
      re_q          <= re_d;
      we_q          <= we_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd_data = rsp_rd_data_q;
  assign rsp_err     = rsp_err_q;
  assign bus_in      = {bus_clk, ~bus_reset, addr_q, wdata_q, re_q, we_q};

`ifdef BUS_MASTER_IRQ_EN
  logic irq_q, irq_d;

  // Set wins over clear so a coincident interrupt is never lost
  always_comb begin
    irq_d = bus_out[BUS_OUT_IRQ] | (irq_q & ~irq_clr);
  end

  always_ff @(posedge bus_clk) begin
    if (bus_reset) irq_q <= 1'b0;
    else           irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = bus_out[BUS_OUT_IRQ];
`endif

endmodule

// File: tb/tb_bus_master_bridge.sv
// Directed bench for bus_master_bridge with a registered-ack split-register slave at 0x10.
module tb_bus_master_bridge;
  import bus_master_bridge_pkg::*;

  logic                      bus_clk = 1'b0;
  logic                      bus_reset = 1'b1;
  logic                      cmd_valid = 1'b0;
  logic                      cmd_ready;
  logic                      cmd_we = 1'b0;
  logic [BUS_ADDR_WIDTH-1:0] cmd_addr = '0;
  logic [BUS_DATA_WIDTH-1:0] cmd_wr_data = '0;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b0;
  logic [BUS_DATA_WIDTH-1:0] rsp_rd_data;
  logic                      rsp_err;
  logic [BUS_IN_WIDTH-1:0]   bus_in;
  logic [BUS_OUT_WIDTH-1:0]  bus_out;
`ifdef BUS_MASTER_IRQ_EN
  logic                      irq;
  logic                      irq_clr = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 bus_clk = ~bus_clk;

  bus_master_bridge #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .bus_clk(bus_clk), .bus_reset(bus_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err),
    .bus_in(bus_in), .bus_out(bus_out)
`ifdef BUS_MASTER_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );

  // Bus field decode
  logic                      b_re, b_we, b_reset_l;
  logic [BUS_ADDR_WIDTH-1:0] b_addr;
  logic [BUS_DATA_WIDTH-1:0] b_wdata;
  assign b_re      = bus_in[BUS_IN_RE];
  assign b_we      = bus_in[BUS_IN_WE];
  assign b_reset_l = bus_in[BUS_IN_RESET_L];
  assign b_addr    = bus_in[BUS_IN_ADDR_LSB +: BUS_ADDR_WIDTH];
  assign b_wdata   = bus_in[BUS_IN_WDATA_LSB +: BUS_DATA_WIDTH];

  // Split-register slave at 0x10 with registered acks, plus direct injection
  logic [BUS_DATA_WIDTH-1:0] slave_in = '0;
  logic [BUS_DATA_WIDTH-1:0] slave_out;
  logic [BUS_DATA_WIDTH-1:0] s_rd_data;
  logic                      s_rd_ack, s_wr_ack;
  logic [BUS_DATA_WIDTH-1:0] inj_data = '0;
  logic                      inj_rd_ack = 1'b0, inj_wr_ack = 1'b0, inj_irq = 1'b0;

  always @(posedge bus_clk) begin
    if (!b_reset_l) begin
      s_rd_ack  <= 1'b0;
      s_wr_ack  <= 1'b0;
      s_rd_data <= '0;
      slave_out <= '0;
    end else begin
      s_rd_ack  <= 1'b0;
      s_wr_ack  <= 1'b0;
      s_rd_data <= '0;
      if (b_re && b_addr == 16'h0010) begin
        s_rd_ack  <= 1'b1;
        s_rd_data <= slave_in;
      end
      if (b_we && b_addr == 16'h0010) begin
        s_wr_ack  <= 1'b1;
        slave_out <= b_wdata;
      end
    end
  end

  assign bus_out = {s_rd_data, s_rd_ack, s_wr_ack, 1'b0} |
                   {inj_data, inj_rd_ack, inj_wr_ack, inj_irq};

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  // Presents one command for exactly one accept edge; returns in the strobe cycle
  task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] data);
    cmd_valid   = 1'b1;
    cmd_we      = we;
    cmd_addr    = addr;
    cmd_wr_data = data;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus_reset = 1'b1;
    tick();
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    tests++; if (rsp_err !== 1'b0 || rsp_rd_data !== 32'h0) begin fails++; $display("FAIL reset_rsp got err=%b data=%h exp 0/0", rsp_err, rsp_rd_data); end
    tests++; if (bus_in[BUS_IN_RESET_L-1:0] !== 50'h0) begin fails++; $display("FAIL reset_bus_fields got %h exp 0", bus_in[BUS_IN_RESET_L-1:0]); end
    tests++; if (b_reset_l !== 1'b0) begin fails++; $display("FAIL reset_l_asserted got %b exp 0", b_reset_l); end
    bus_reset = 1'b0;
    #1;
    tests++; if (b_reset_l !== 1'b1) begin fails++; $display("FAIL reset_l_released got %b exp 1", b_reset_l); end
    tick();
  endtask

  task automatic test_write();
    issue(1'b1, 16'h0010, 32'h000000A5);
    tests++; if (b_we !== 1'b1 || b_re !== 1'b0) begin fails++; $display("FAIL wr_strobe got we=%b re=%b exp 1/0", b_we, b_re); end
    tests++; if (b_addr !== 16'h0010 || b_wdata !== 32'hA5) begin fails++; $display("FAIL wr_fields got addr=%h data=%h exp 0010/000000a5", b_addr, b_wdata); end
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL wr_busy got %b exp 0", cmd_ready); end
    tick();
    tests++; if (b_we !== 1'b0 || rsp_valid !== 1'b0 || b_addr !== 16'h0010) begin fails++; $display("FAIL wr_wait got we=%b valid=%b addr=%h exp 0/0/0010", b_we, rsp_valid, b_addr); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rd_data !== 32'h0) begin fails++; $display("FAIL wr_rsp got valid=%b err=%b data=%h exp 1/0/0", rsp_valid, rsp_err, rsp_rd_data); end
    tests++; if (slave_out !== 32'hA5) begin fails++; $display("FAIL wr_slave got %h exp 000000a5", slave_out); end
    handshake();
    tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL wr_done got valid=%b ready=%b exp 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_read();
    slave_in = 32'h00001234;
    issue(1'b0, 16'h0010, 32'h0);
    tests++; if (b_re !== 1'b1 || b_we !== 1'b0) begin fails++; $display("FAIL rd_strobe got re=%b we=%b exp 1/0", b_re, b_we); end
    tick();
    tests++; if (b_re !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_wait got re=%b valid=%b exp 0/0", b_re, rsp_valid); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rd_data !== 32'h00001234) begin fails++; $display("FAIL rd_rsp got valid=%b err=%b data=%h exp 1/0/00001234", rsp_valid, rsp_err, rsp_rd_data); end
    handshake();
  endtask

  task automatic test_timeout();
    logic seen;
    issue(1'b0, 16'h0040, 32'h0);
    for (int i = 0; i < 16; i++) tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL to_early got valid=%b exp 0", rsp_valid); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rd_data !== 32'hDEADBEEF) begin fails++; $display("FAIL to_rsp got valid=%b err=%b data=%h exp 1/1/deadbeef", rsp_valid, rsp_err, rsp_rd_data); end
    handshake();
    tick();
    tick();
    inj_rd_ack = 1'b1;
    inj_data   = 32'h12345678;
    tick();
    inj_rd_ack = 1'b0;
    inj_data   = '0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) seen = 1'b1;
      tick();
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL to_late_ack got response=%b exp 0", seen); end
  endtask

  task automatic test_ack_at_expiry();
    issue(1'b0, 16'h0040, 32'h0);
    for (int i = 0; i < 16; i++) tick();
    inj_rd_ack = 1'b1;
    inj_data   = 32'h5555AAAA;
    tick();
    inj_rd_ack = 1'b0;
    inj_data   = '0;
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rd_data !== 32'h5555AAAA) begin fails++; $display("FAIL expiry_ack got valid=%b err=%b data=%h exp 1/0/5555aaaa", rsp_valid, rsp_err, rsp_rd_data); end
    handshake();
  endtask

  task automatic test_wrong_ack();
    issue(1'b1, 16'h0040, 32'h000000FF);
    tick();
    inj_rd_ack = 1'b1;
    inj_data   = 32'h0000CAFE;
    for (int i = 0; i < 4; i++) tick();
    inj_rd_ack = 1'b0;
    inj_data   = '0;
    for (int i = 0; i < 11; i++) tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wrong_ack_early got valid=%b exp 0", rsp_valid); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rd_data !== 32'h0) begin fails++; $display("FAIL wrong_ack_rsp got valid=%b err=%b data=%h exp 1/1/0", rsp_valid, rsp_err, rsp_rd_data); end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic bad;
    slave_in = 32'h00000077;
    issue(1'b0, 16'h0010, 32'h0);
    tick();
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h77) begin fails++; $display("FAIL b2b_rsp got valid=%b data=%h exp 1/00000077", rsp_valid, rsp_rd_data); end
    slave_in    = 32'h00000099;
    cmd_valid   = 1'b1;
    cmd_we      = 1'b1;
    cmd_addr    = 16'h0010;
    cmd_wr_data = 32'h0000003C;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h77 || rsp_err !== 1'b0 || cmd_ready !== 1'b0 || b_we !== 1'b0) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL b2b_hold got unstable=%b exp 0", bad); end
    handshake();
    cmd_valid = 1'b1;
    tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || b_we !== 1'b0) begin fails++; $display("FAIL b2b_idle got valid=%b ready=%b we=%b exp 0/1/0", rsp_valid, cmd_ready, b_we); end
    tick();
    cmd_valid = 1'b0;
    tests++; if (b_we !== 1'b1 || b_wdata !== 32'h3C) begin fails++; $display("FAIL b2b_accept got we=%b data=%h exp 1/0000003c", b_we, b_wdata); end
    tick();
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || slave_out !== 32'h3C) begin fails++; $display("FAIL b2b_second got valid=%b err=%b slave=%h exp 1/0/0000003c", rsp_valid, rsp_err, slave_out); end
    handshake();
  endtask

  task automatic test_reset_mid();
    logic seen;
    issue(1'b0, 16'h0040, 32'h0);
    tick();
    tick();
    bus_reset = 1'b1;
    #1;
    tests++; if (b_reset_l !== 1'b0) begin fails++; $display("FAIL mid_reset_l got %b exp 0", b_reset_l); end
    tick();
    bus_reset = 1'b0;
    tests++; if (cmd_ready !== 1'b1 || b_re !== 1'b0 || b_we !== 1'b0 || rsp_valid !== 1'b0 || b_addr !== 16'h0) begin fails++; $display("FAIL mid_reset_idle got ready=%b re=%b we=%b valid=%b addr=%h exp 1/0/0/0/0", cmd_ready, b_re, b_we, rsp_valid, b_addr); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_reset_stale got response=%b exp 0", seen); end
  endtask

`ifdef BUS_MASTER_IRQ_EN
  task automatic test_irq();
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_init got %b exp 0", irq); end
    inj_irq = 1'b1;
    tick();
    inj_irq = 1'b0;
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set got %b exp 1", irq); end
    for (int i = 0; i < 3; i++) tick();
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_sticky got %b exp 1", irq); end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clr got %b exp 0", irq); end
    inj_irq = 1'b1;
    irq_clr = 1'b1;
    tick();
    inj_irq = 1'b0;
    irq_clr = 1'b0;
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set_clr got %b exp 1", irq); end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clr2 got %b exp 0", irq); end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_at_expiry();
    test_wrong_ack();
    test_back_to_back();
    test_reset_mid();
`ifdef BUS_MASTER_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule
